id_stage_pipe: RTL and testbench

- Parametrised pipelined decode stage for the RV32I core.
- Decodes the instruction, reads and writes a parametrised register file, and generates the I/S/B/U/J immediate.
- Registers all results into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Adds load-use hazard stalling, flush, and an illegal-opcode flag, all absent from the single-cycle decode.

---
 rtl/id_stage_pipe.sv | 266 ++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Pipelined RV32I decode stage. Decodes the incoming instruction, reads the
// register file, builds the sign-extended immediate and registers everything
// into the ID/EX pipeline register. Valid/ready handshakes are used on both the
// fetch side and the execute side. It also stalls on load-use hazards,
// supports flush, and flags unknown opcodes.
//
// Optional build macro:
//   ID_WB_BYPASS_EN - when defined, a same-cycle write-back to a source register
//                     is forwarded into the captured operand (write-through).
//                     When undefined, the pre-write register value is captured,
//                     and EX forwarding must resolve the case.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_valid/if_ready   fetch handshake
//   if_inst, if_pc      instruction word and its PC
//   wb_regwrite/wb_rd/wb_data   register-file write port
//   flush               squash ID/EX entry and the incoming instruction
//   ex_ready/ex_valid   execute-side handshake
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm            registered data
//   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_inst30        registered fields
//   ex_ctrl             [10]branch [9]memread [8]memtoreg [7:6]aluop
//                       [5]memwrite [4]alusrc [3]regwrite [2]aluinputpc
//                       [1]getpcplus4 [0]alu2pc
//   ex_illegal          registered unknown-opcode flag
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [XLEN-1:0]       if_inst,
    input  logic [XLEN-1:0]       if_pc,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic                  ex_inst30,
    output logic [10:0]           ex_ctrl,
    output logic                  ex_illegal
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [REG_ADDR_W:0] NREGS = (REG_ADDR_W+1)'(NUM_REGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [10:0] CTRL_R      = 11'h088;
    localparam logic [10:0] CTRL_IMM    = 11'h0D8;
    localparam logic [10:0] CTRL_LOAD   = 11'h318;
    localparam logic [10:0] CTRL_STORE  = 11'h030;
    localparam logic [10:0] CTRL_BRANCH = 11'h440;
    localparam logic [10:0] CTRL_JAL    = 11'h40A;
    localparam logic [10:0] CTRL_JALR   = 11'h01B;
    localparam logic [10:0] CTRL_AUIPC  = 11'h01C;
    localparam logic [10:0] CTRL_LUI    = 11'h018;

    logic [XLEN-1:0] regs [NUM_REGS];

    logic                  wb_hit;
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;
    logic [REG_ADDR_W-1:0] rd_idx;
    logic [10:0]           ctrl;
    logic                  illegal;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic signed [31:0]    imm32;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic                  hazard;
    logic                  advance;

    logic                  vld_p1;
    logic [XLEN-1:0]       pc_p1;
    logic [XLEN-1:0]       rs1_data_p1;
    logic [XLEN-1:0]       rs2_data_p1;
    logic [XLEN-1:0]       imm_p1;
    logic [REG_ADDR_W-1:0] rs1_p1;
    logic [REG_ADDR_W-1:0] rs2_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic [2:0]            funct3_p1;
    logic                  inst30_p1;
    logic [10:0]           ctrl_p1;
    logic                  illegal_p1;

    function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS);
    endfunction

    // x0 and non-existent registers (e.g. x16..x31 on RV32E) read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [REG_ADDR_W-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != '0 && in_range(a))
            v = regs[a[IDX_W-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wb_hit && wb_rd == a)
            v = wb_data;
`endif
        return v;
    endfunction

    assign wb_hit = wb_regwrite && (wb_rd != '0) && in_range(wb_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_rd[IDX_W-1:0]] <= wb_data;
        end
    end

    // ---- ID stage (p0): combinational decode of if_inst ----
    always_comb begin
        opcode   = if_inst[6:0];
        rd_idx   = if_inst[11:7];
        rs1_idx  = if_inst[19:15];
        rs2_idx  = if_inst[24:20];
        ctrl     = '0;
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm32    = '0;
        case (opcode)
            OP_R: begin
                ctrl     = CTRL_R;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl     = CTRL_IMM;
                uses_rs1 = 1'b1;
                imm32    = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OP_LOAD: begin
                ctrl     = CTRL_LOAD;
                uses_rs1 = 1'b1;
                imm32    = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OP_STORE: begin
                ctrl     = CTRL_STORE;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            end
            OP_BRANCH: begin
                ctrl     = CTRL_BRANCH;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm32    = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                            if_inst[30:25], if_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl  = CTRL_JAL;
                imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                         if_inst[20], if_inst[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl     = CTRL_JALR;
                uses_rs1 = 1'b1;
                imm32    = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            OP_AUIPC: begin
                ctrl  = CTRL_AUIPC;
                imm32 = {if_inst[31:12], 12'b0};
            end
            OP_LUI: begin
                ctrl    = CTRL_LUI;
                rs1_idx = '0;    // upper bits of the immediate, not a source
                imm32   = {if_inst[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign imm      = XLEN'(imm32);
    assign rs1_data = rf_read(rs1_idx);
    assign rs2_data = rf_read(rs2_idx);

    // A load in EX cannot forward in time for its consumer: insert one bubble.
    assign hazard  = vld_p1 && ctrl_p1[9] && (rd_p1 != '0) &&
                     ((uses_rs1 && rs1_idx == rd_p1) ||
                      (uses_rs2 && rs2_idx == rd_p1));
    assign advance = !vld_p1 || ex_ready;
    // During flush the offered instruction is consumed (and dropped).
    assign if_ready = flush || (advance && !hazard);

    // ---- ID/EX boundary (p1) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            funct3_p1   <= '0;
            inst30_p1   <= 1'b0;
            ctrl_p1     <= '0;
            illegal_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            if (hazard || !if_valid) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1      <= 1'b1;
                pc_p1       <= if_pc;
                rs1_data_p1 <= rs1_data;
                rs2_data_p1 <= rs2_data;
                imm_p1      <= imm;
                rs1_p1      <= rs1_idx;
                rs2_p1      <= rs2_idx;
                rd_p1       <= rd_idx;
                funct3_p1   <= if_inst[14:12];
                inst30_p1   <= if_inst[30];
                ctrl_p1     <= ctrl;
                illegal_p1  <= illegal;
            end
        end
    end

    assign ex_valid    = vld_p1;
    assign ex_pc       = pc_p1;
    assign ex_rs1_data = rs1_data_p1;
    assign ex_rs2_data = rs2_data_p1;
    assign ex_imm      = imm_p1;
    assign ex_rs1      = rs1_p1;
    assign ex_rs2      = rs2_p1;
    assign ex_rd       = rd_p1;
    assign ex_funct3   = funct3_p1;
    assign ex_inst30   = inst30_p1;
    assign ex_ctrl     = ctrl_p1;
    assign ex_illegal  = illegal_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed-vector bench for id_stage_pipe. A second instance built with
// NUM_REGS=16 shares all inputs with the main instance and is checked for
// out-of-range register handling.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;

    logic        if_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_inst30;
    logic [10:0] ex_ctrl;
    logic        ex_illegal;

    logic        d16_if_ready;
    logic        d16_ex_valid;
    logic [31:0] d16_ex_pc, d16_ex_rs1_data, d16_ex_rs2_data, d16_ex_imm;
    logic [4:0]  d16_ex_rs1, d16_ex_rs2, d16_ex_rd;
    logic [2:0]  d16_ex_funct3;
    logic        d16_ex_inst30;
    logic [10:0] d16_ex_ctrl;
    logic        d16_ex_illegal;

    int n_cmp;
    int n_err;

    logic [31:0] exp_bypass;

    id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .REG_ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_inst30(ex_inst30), .ex_ctrl(ex_ctrl),
        .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(32), .NUM_REGS(16), .REG_ADDR_W(5)) u_dut16 (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(d16_if_ready),
        .if_inst(if_inst), .if_pc(if_pc),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(d16_ex_valid),
        .ex_pc(d16_ex_pc), .ex_rs1_data(d16_ex_rs1_data), .ex_rs2_data(d16_ex_rs2_data),
        .ex_imm(d16_ex_imm), .ex_rs1(d16_ex_rs1), .ex_rs2(d16_ex_rs2), .ex_rd(d16_ex_rd),
        .ex_funct3(d16_ex_funct3), .ex_inst30(d16_ex_inst30), .ex_ctrl(d16_ex_ctrl),
        .ex_illegal(d16_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_regwrite = 1'b1;
        wb_rd       = rd;
        wb_data     = data;
        step();
        wb_regwrite = 1'b0;
    endtask

    // Offer one instruction with EX ready; it is captured on the next edge.
    task automatic accept(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        step();
        if_valid = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        if_valid    = 1'b0;
        if_inst     = '0;
        if_pc       = '0;
        wb_regwrite = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        flush       = 1'b0;
        ex_ready    = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ctrl", {21'b0, ex_ctrl}, 32'h0);
        chk("rst_pc", ex_pc, 32'h0);
        rst = 1'b1;
        step();

        // Basic R-type with operand read
        wb_write(5'd5, 32'h0000_1234);
        if_valid = 1'b1;
        if_inst  = 32'h0002_81B3;   // add x3,x5,x0
        if_pc    = 32'h0000_0100;
        #1;
        chk("add_if_ready", {31'b0, if_ready}, 32'h1);
        step();
        if_valid = 1'b0;
        chk("add_valid", {31'b0, ex_valid}, 32'h1);
        chk("add_rs1_data", ex_rs1_data, 32'h0000_1234);
        chk("add_ctrl", {21'b0, ex_ctrl}, 32'h088);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_rs1", {27'b0, ex_rs1}, 32'd5);
        chk("add_pc", ex_pc, 32'h0000_0100);
        chk("add_imm", ex_imm, 32'h0);

        // Load-use hazard
        accept(32'h0000_A383, 32'h0000_0104);   // lw x7,0(x1)
        chk("lw_ctrl", {21'b0, ex_ctrl}, 32'h318);
        chk("lw_rd", {27'b0, ex_rd}, 32'd7);
        chk("lw_funct3", {29'b0, ex_funct3}, 32'd2);
        if_valid = 1'b1;
        if_inst  = 32'h0023_8433;               // add x8,x7,x2
        if_pc    = 32'h0000_0108;
        #1;
        chk("hz_if_ready", {31'b0, if_ready}, 32'h0);
        step();
        chk("hz_bubble", {31'b0, ex_valid}, 32'h0);
        chk("hz_if_ready2", {31'b0, if_ready}, 32'h1);
        step();
        if_valid = 1'b0;
        chk("hz_add_valid", {31'b0, ex_valid}, 32'h1);
        chk("hz_add_rd", {27'b0, ex_rd}, 32'd8);
        chk("hz_add_rs2", {27'b0, ex_rs2}, 32'd2);
        chk("hz_add_pc", ex_pc, 32'h0000_0108);

        // Flush drops both the ID/EX entry and the offered instruction
        if_valid = 1'b1;
        flush    = 1'b1;
        if_inst  = 32'hFFF0_0093;
        #1;
        chk("fl_if_ready", {31'b0, if_ready}, 32'h1);
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("fl_valid", {31'b0, ex_valid}, 32'h0);
        step();
        chk("fl_not_kept", {31'b0, ex_valid}, 32'h0);

        // I-type immediate, then EX back-pressure for 3 cycles
        accept(32'hFFF0_0093, 32'h0000_0200);   // addi x1,x0,-1
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
        chk("addi_ctrl", {21'b0, ex_ctrl}, 32'h0D8);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_inst  = 32'h1234_5237;               // lui x4,0x12345
        if_pc    = 32'h0000_0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_if_ready", {31'b0, if_ready}, 32'h0);
            step();
            chk("st_valid", {31'b0, ex_valid}, 32'h1);
            chk("st_pc", ex_pc, 32'h0000_0200);
            chk("st_imm", ex_imm, 32'hFFFF_FFFF);
            chk("st_rd", {27'b0, ex_rd}, 32'd1);
        end
        ex_ready = 1'b1;
        step();
        if_valid = 1'b0;
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_ctrl", {21'b0, ex_ctrl}, 32'h018);
        chk("lui_rs1", {27'b0, ex_rs1}, 32'd0);
        chk("lui_pc", ex_pc, 32'h0000_0204);

        // S, B and J immediates
        accept(32'h0020_A423, 32'h0000_0300);   // sw x2,8(x1)
        chk("sw_imm", ex_imm, 32'd8);
        chk("sw_ctrl", {21'b0, ex_ctrl}, 32'h030);
        accept(32'hFE00_0EE3, 32'h0000_0304);   // beq x0,x0,-4
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_ctrl", {21'b0, ex_ctrl}, 32'h440);
        accept(32'h0080_00EF, 32'h0000_0308);   // jal x1,8
        chk("jal_imm", ex_imm, 32'd8);
        chk("jal_ctrl", {21'b0, ex_ctrl}, 32'h40A);

        // Illegal opcode
        accept(32'h0000_007F, 32'h0000_030C);
        chk("ill_flag", {31'b0, ex_illegal}, 32'h1);
        chk("ill_ctrl", {21'b0, ex_ctrl}, 32'h0);
        chk("ill_imm", ex_imm, 32'h0);

        // x0 is never written
        wb_write(5'd0, 32'h0000_DEAD);
        accept(32'h0000_00B3, 32'h0000_0310);   // add x1,x0,x0
        chk("x0_read", ex_rs1_data, 32'h0);
        chk("x0_ill_clr", {31'b0, ex_illegal}, 32'h0);

        // Same-cycle write-back and read of x9
        wb_write(5'd9, 32'h0000_0011);
`ifdef ID_WB_BYPASS_EN
        exp_bypass = 32'h0000_00AA;
`else
        exp_bypass = 32'h0000_0011;
`endif
        wb_regwrite = 1'b1;
        wb_rd       = 5'd9;
        wb_data     = 32'h0000_00AA;
        accept(32'h0004_80B3, 32'h0000_0314);   // add x1,x9,x0
        wb_regwrite = 1'b0;
        chk("byp_rs1", ex_rs1_data, exp_bypass);
        accept(32'h0004_80B3, 32'h0000_0318);
        chk("byp_after", ex_rs1_data, 32'h0000_00AA);

        // x20 exists with 32 registers, not with 16
        wb_write(5'd20, 32'h0000_0055);
        accept(32'h000A_00B3, 32'h0000_031C);   // add x1,x20,x0
        chk("x20_n32", ex_rs1_data, 32'h0000_0055);
        chk("x20_n16", d16_ex_rs1_data, 32'h0);
        chk("n16_valid", {31'b0, d16_ex_valid}, 32'h1);

        // Reset asserted while stalled clears immediately
        ex_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_stall_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_stall_ctrl", {21'b0, ex_ctrl}, 32'h0);
        chk("rst_stall_pc", ex_pc, 32'h0);
        step();
        rst      = 1'b1;
        ex_ready = 1'b1;
        step();
        chk("rst_not_kept", {31'b0, ex_valid}, 32'h0);
        accept(32'h0004_80B3, 32'h0000_0400);
        chk("rst_rf_clr", ex_rs1_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
